// File: rtl/button_event_arbiter.sv
// Latches per-button press/release pulses and offers them round-robin as one valid/ready
// event stream. Define AUTOREPEAT_EN to add held-button repeat events (kind 2'b10).
module button_event_arbiter #(
   parameter int unsigned N          = 4,
   parameter int unsigned IDW        = 2,
   parameter logic [23:0] RPT_DELAY  = 24'd12_000_000,
   parameter logic [23:0] RPT_PERIOD = 24'd3_000_000
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   btn_down,
   input  logic [N-1:0]   btn_up,
   input  logic [N-1:0]   btn_state,
   output logic           ev_valid,
   input  logic           ev_ready,
   output logic [IDW-1:0] ev_id,
   output logic [1:0]     ev_kind,
   output logic           ovf
);

   if (N < 2 || N > 8 || IDW != $clog2(N) || RPT_DELAY == 24'd0 || RPT_PERIOD == 24'd0)
   begin : g_param_check
      $error("button_event_arbiter: illegal parameter set");
   end

   typedef enum logic {ST_IDLE, ST_OFFER} state_t;
   typedef enum logic [1:0] {KIND_PRESS = 2'b00, KIND_REL = 2'b01, KIND_RPT = 2'b10} kind_t;

   state_t         r_state, w_state_nxt;
   kind_t          r_kind, w_sel_kind;
   logic [IDW-1:0] r_id, w_sel_id, r_rr_ptr;
   logic [N-1:0]   r_press_pend, r_rel_pend;
   logic [N-1:0]   w_clr_press, w_clr_rel;
   logic           r_ovf, w_hs, w_load, w_sel_found;
   logic           w_rpt_pend;
   logic [IDW-1:0] w_rpt_id;

   assign ev_valid = (r_state == ST_OFFER);
   assign ev_id    = r_id;
   assign ev_kind  = r_kind;
   assign ovf      = r_ovf;
   assign w_hs     = (r_state == ST_OFFER) && ev_ready;

   assign w_clr_press = (w_hs && r_kind == KIND_PRESS) ? (N'(1) << r_id) : '0;
   assign w_clr_rel   = (w_hs && r_kind == KIND_REL)   ? (N'(1) << r_id) : '0;

   // Scan from rr_ptr with explicit wrap so non-power-of-two N never indexes past N-1.
   always_comb begin : p_select
      logic [IDW:0] v_idx;
      v_idx       = '0;
      w_sel_found = 1'b0;
      w_sel_id    = '0;
      w_sel_kind  = KIND_PRESS;
      for (int unsigned k = 0; k < N; k++) begin
         v_idx = {1'b0, r_rr_ptr} + (IDW+1)'(k);
         if (v_idx >= (IDW+1)'(N)) v_idx = v_idx - (IDW+1)'(N);
         if (!w_sel_found) begin
            if (r_press_pend[v_idx[IDW-1:0]]) begin
               w_sel_found = 1'b1;
               w_sel_id    = v_idx[IDW-1:0];
               w_sel_kind  = KIND_PRESS;
            end else if (r_rel_pend[v_idx[IDW-1:0]]) begin
               w_sel_found = 1'b1;
               w_sel_id    = v_idx[IDW-1:0];
               w_sel_kind  = KIND_REL;
            end
         end
      end
      if (!w_sel_found && w_rpt_pend) begin
         w_sel_found = 1'b1;
         w_sel_id    = w_rpt_id;
         w_sel_kind  = KIND_RPT;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      unique case (r_state)
         ST_IDLE: if (w_sel_found) begin
            w_load      = 1'b1;
            w_state_nxt = ST_OFFER;
         end
         ST_OFFER: if (ev_ready) w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_id         <= '0;
         r_kind       <= KIND_PRESS;
         r_rr_ptr     <= '0;
         r_press_pend <= '0;
         r_rel_pend   <= '0;
         r_ovf        <= 1'b0;
      end else begin
         if (w_load) begin
            r_id   <= w_sel_id;
            r_kind <= w_sel_kind;
         end
         if (w_hs) r_rr_ptr <= (r_id == IDW'(N-1)) ? '0 : r_id + 1'b1;
         // A set in the same cycle as a clear keeps the flag pending.
         r_press_pend <= (r_press_pend & ~w_clr_press) | btn_down;
         r_rel_pend   <= (r_rel_pend & ~w_clr_rel) | btn_up;
         r_ovf        <= |(btn_down & r_press_pend & ~w_clr_press) |
                         |(btn_up & r_rel_pend & ~w_clr_rel);
      end
   end

`ifdef AUTOREPEAT_EN
   logic [23:0]    r_rpt_cnt, w_rpt_lim;
   logic [IDW-1:0] r_rpt_id, w_low_id;
   logic           r_rpt_armed, r_rpt_first, r_rpt_pend, w_rpt_clr;

   assign w_rpt_pend = r_rpt_pend;
   assign w_rpt_id   = r_rpt_id;
   assign w_rpt_clr  = w_hs && r_kind == KIND_RPT;
   assign w_rpt_lim  = r_rpt_first ? RPT_DELAY - 24'd1 : RPT_PERIOD - 24'd1;

   always_comb begin
      w_low_id = '0;
      for (int unsigned i = N; i > 0; i--)
         if (btn_down[i-1]) w_low_id = IDW'(i-1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rpt_cnt   <= '0;
         r_rpt_id    <= '0;
         r_rpt_armed <= 1'b0;
         r_rpt_first <= 1'b0;
         r_rpt_pend  <= 1'b0;
      end else begin
         if (w_rpt_clr) r_rpt_pend <= 1'b0;
         if (|btn_down) begin
            r_rpt_armed <= 1'b1;
            r_rpt_id    <= w_low_id;
            r_rpt_cnt   <= '0;
            r_rpt_first <= 1'b1;
            r_rpt_pend  <= 1'b0;
         end else if (r_rpt_armed && (!btn_state[r_rpt_id] || btn_up[r_rpt_id])) begin
            r_rpt_armed <= 1'b0;
            r_rpt_pend  <= 1'b0;
         end else if (r_rpt_armed) begin
            if (r_rpt_cnt == w_rpt_lim) begin
               r_rpt_cnt   <= '0;
               r_rpt_first <= 1'b0;
               r_rpt_pend  <= 1'b1;
            end else begin
               r_rpt_cnt <= r_rpt_cnt + 24'd1;
            end
         end
      end
   end
`else
   logic w_unused_state;
   assign w_unused_state = ^btn_state;
   assign w_rpt_pend     = 1'b0;
   assign w_rpt_id       = '0;
`endif

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed self-checking bench for button_event_arbiter; the repeat scenario is
// compiled only when AUTOREPEAT_EN is defined.
module tb_button_event_arbiter;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] btn_down = '0, btn_up = '0, btn_state = '0;
   logic       ev_ready = 1'b0;
   logic       ev_valid, ovf;
   logic [1:0] ev_id, ev_kind;
   int         n_tests = 0;
   int         n_fail  = 0;

   button_event_arbiter #(
      .N(4), .IDW(2), .RPT_DELAY(24'd10), .RPT_PERIOD(24'd4)
   ) dut (
      .clk(clk), .rst(rst), .btn_down(btn_down), .btn_up(btn_up),
      .btn_state(btn_state), .ev_valid(ev_valid), .ev_ready(ev_ready),
      .ev_id(ev_id), .ev_kind(ev_kind), .ovf(ovf)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; btn_down = '0; btn_up = '0; btn_state = '0; ev_ready = 1'b0;
      step(); step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_tests++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", ev_valid); end
      n_tests++; if (ev_id !== 2'd0) begin n_fail++; $display("FAIL reset_id got %0d want 0", ev_id); end
      n_tests++; if (ev_kind !== 2'b00) begin n_fail++; $display("FAIL reset_kind got %b want 00", ev_kind); end
      n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", ovf); end
   endtask

   task automatic test_single_press();
      do_reset();
      ev_ready = 1'b1;
      btn_down = 4'b0100;
      step(); btn_down = '0;
      n_tests++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL single_early got %b want 0", ev_valid); end
      step();
      n_tests++; if (ev_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b want 1", ev_valid); end
      n_tests++; if (ev_id !== 2'd2) begin n_fail++; $display("FAIL single_id got %0d want 2", ev_id); end
      n_tests++; if (ev_kind !== 2'b00) begin n_fail++; $display("FAIL single_kind got %b want 00", ev_kind); end
      step();
      n_tests++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL single_drop got %b want 0", ev_valid); end
   endtask

   task automatic test_round_robin();
      logic       exp_v;
      logic [1:0] exp_id;
      do_reset();
      ev_ready = 1'b1;
      for (int unsigned burst = 0; burst < 2; burst++) begin
         btn_down = 4'b1111;
         for (int c = 1; c <= 9; c++) begin
            step(); btn_down = '0;
            exp_v  = (c % 2 == 0) && (c <= 8);
            exp_id = 2'((c - 2) / 2);
            n_tests++;
            if (ev_valid !== exp_v) begin
               n_fail++; $display("FAIL rr_valid burst %0d cyc %0d got %b want %b", burst, c, ev_valid, exp_v);
            end
            if (exp_v) begin
               n_tests++;
               if (ev_id !== exp_id || ev_kind !== 2'b00) begin
                  n_fail++; $display("FAIL rr_id burst %0d cyc %0d got id %0d kind %b want id %0d kind 00",
                                     burst, c, ev_id, ev_kind, exp_id);
               end
            end
         end
      end
   endtask

   task automatic test_backpressure();
      int unsigned n_ev;
      do_reset();
      btn_down = 4'b0010;
      step(); btn_down = '0;
      step();
      for (int c = 0; c < 20; c++) begin
         n_tests++;
         if (ev_valid !== 1'b1 || ev_id !== 2'd1 || ev_kind !== 2'b00 || ovf !== 1'b0) begin
            n_fail++; $display("FAIL bp_hold cyc %0d got v%b id%0d k%b ovf%b want v1 id1 k00 ovf0",
                               c, ev_valid, ev_id, ev_kind, ovf);
         end
         step();
      end
      btn_down = 4'b0010;
      step(); btn_down = '0;
      n_tests++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL bp_ovf got %b want 1", ovf); end
      step();
      n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL bp_ovf_pulse got %b want 0", ovf); end
      ev_ready = 1'b1;
      n_ev = 0;
      for (int c = 0; c < 8; c++) begin
         if (ev_valid === 1'b1) n_ev++;
         step();
      end
      n_tests++; if (n_ev != 1) begin n_fail++; $display("FAIL bp_count got %0d events want 1", n_ev); end
   endtask

   task automatic test_press_release();
      do_reset();
      btn_down = 4'b1000;
      step(); btn_down = '0; btn_up = 4'b1000;
      step(); btn_up = '0;
      n_tests++;
      if (ev_valid !== 1'b1 || ev_id !== 2'd3 || ev_kind !== 2'b00) begin
         n_fail++; $display("FAIL pr_first got v%b id%0d k%b want v1 id3 k00", ev_valid, ev_id, ev_kind);
      end
      ev_ready = 1'b1;
      step();
      n_tests++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL pr_gap got %b want 0", ev_valid); end
      step();
      n_tests++;
      if (ev_valid !== 1'b1 || ev_id !== 2'd3 || ev_kind !== 2'b01) begin
         n_fail++; $display("FAIL pr_second got v%b id%0d k%b want v1 id3 k01", ev_valid, ev_id, ev_kind);
      end
      step();
      n_tests++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL pr_done got %b want 0", ev_valid); end
   endtask

   task automatic test_set_wins();
      do_reset();
      btn_down = 4'b0100;
      step(); btn_down = '0;
      step();
      ev_ready = 1'b1; btn_down = 4'b0100;
      step(); btn_down = '0;
      n_tests++;
      if (ev_valid !== 1'b0 || ovf !== 1'b0) begin
         n_fail++; $display("FAIL sw_hs got v%b ovf%b want v0 ovf0", ev_valid, ovf);
      end
      step();
      n_tests++;
      if (ev_valid !== 1'b1 || ev_id !== 2'd2 || ev_kind !== 2'b00) begin
         n_fail++; $display("FAIL sw_again got v%b id%0d k%b want v1 id2 k00", ev_valid, ev_id, ev_kind);
      end
      step();
      n_tests++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL sw_end got %b want 0", ev_valid); end
   endtask

   task automatic test_reset_mid_offer();
      do_reset();
      btn_down = 4'b0001; btn_up = 4'b0010;
      step(); btn_down = '0; btn_up = '0;
      step();
      n_tests++; if (ev_valid !== 1'b1) begin n_fail++; $display("FAIL rmo_pre got %b want 1", ev_valid); end
      #2 rst = 1'b1;
      #1;
      n_tests++;
      if (ev_valid !== 1'b0 || ev_id !== 2'd0 || ev_kind !== 2'b00 || ovf !== 1'b0) begin
         n_fail++; $display("FAIL rmo_async got v%b id%0d k%b ovf%b want all 0", ev_valid, ev_id, ev_kind, ovf);
      end
      step();
      rst = 1'b0; ev_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         step();
         n_tests++;
         if (ev_valid !== 1'b0 || ovf !== 1'b0) begin
            n_fail++; $display("FAIL rmo_after cyc %0d got v%b ovf%b want v0 ovf0", c, ev_valid, ovf);
         end
      end
   endtask

`ifdef AUTOREPEAT_EN
   task automatic test_autorepeat();
      logic       exp_v;
      logic [1:0] exp_k;
      do_reset();
      ev_ready = 1'b1;
      btn_state = 4'b0001; btn_down = 4'b0001;
      for (int s = 1; s <= 36; s++) begin
         step();
         btn_down = '0; btn_up = '0;
         exp_v = 1'b1; exp_k = 2'b10;
         case (s)
            2:              exp_k = 2'b00;
            12, 16, 20, 24: exp_k = 2'b10;
            27:             exp_k = 2'b01;
            default:        exp_v = 1'b0;
         endcase
         n_tests++;
         if (ev_valid !== exp_v || (exp_v && (ev_kind !== exp_k || ev_id !== 2'd0))) begin
            n_fail++; $display("FAIL rpt step %0d got v%b id%0d k%b want v%b id0 k%b",
                               s, ev_valid, ev_id, ev_kind, exp_v, exp_k);
         end
         if (s == 25) begin
            btn_state = '0; btn_up = 4'b0001;
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single_press();
      test_round_robin();
      test_backpressure();
      test_press_release();
      test_set_wins();
      test_reset_mid_offer();
`ifdef AUTOREPEAT_EN
      test_autorepeat();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
